regfile_rd_arbiter: RTL

Shares the single register-file read port (the 32-way read mux selected by a 5-bit index) among NUM_REQ requesters, such as the decode rs1/rs2 path, the debug unit and the CSR/trap unit. It uses round-robin arbitration with an optional two-cycle lock, so one requester can fetch rs1 and rs2 on back-to-back cycles. Read data is registered with one-cycle latency. Same-cycle write-back data is forwarded, and x0 always reads as zero.

---
 rtl/regfile_rd_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/regfile_rd_arbiter.sv
// Round-robin arbiter sharing the single register-file read port among
// NUM_REQ requesters. A requester may lock the port for one extra grant so
// that rs1/rs2 reads land on back-to-back cycles. Read data is returned one
// cycle after the grant, with same-cycle write-back forwarding and x0 as zero.
module regfile_rd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 5,
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_lock,
  input  logic [NUM_REQ*ADDR_BITS-1:0] req_addr,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [ADDR_BITS-1:0]         rf_sel,
  input  logic [DATA_BITS-1:0]         rf_rdata,
  input  logic                         wr_en,
  input  logic [ADDR_BITS-1:0]         wr_addr,
  input  logic [DATA_BITS-1:0]         wr_data,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [IDX_W-1:0]             rsp_id,
  output logic [DATA_BITS-1:0]         rsp_data
);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;

  logic                 lock_hold;
  logic                 gnt_any;
  logic                 gnt_vld;
  logic [IDX_W-1:0]     gnt_idx;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic [ADDR_BITS-1:0] gnt_addr;
  logic [DATA_BITS-1:0] rd_data;

  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [IDX_W-1:0]     rsp_id_q;
  logic [DATA_BITS-1:0] rsp_data_q;

  // Successor index with wrap at NUM_REQ (NUM_REQ need not be a power of 2).
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return idx + IDX_W'(1);
  endfunction

  // Pick the winner: locked owner first, otherwise first valid from ptr onward.
  always_comb begin
    logic [IDX_W-1:0] cand;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    lock_hold = (state_q == ST_LOCKED) && req_valid[owner_q];
    if (lock_hold) begin
      gnt_any = 1'b1;
      gnt_idx = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  // No grant is offered while reset is held, even though inputs may be valid.
  assign gnt_vld = gnt_any && reset_n;

  // One-hot grant and the granted requester's register index.
  always_comb begin
    gnt_oh   = '0;
    gnt_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_vld && (gnt_idx == IDX_W'(i))) begin
        gnt_oh[i] = 1'b1;
        gnt_addr  = req_addr[i*ADDR_BITS +: ADDR_BITS];
      end
    end
  end

  assign req_ready = gnt_oh;
  assign rf_sel    = gnt_addr;

  // Read result: x0 is hard zero, then forwarded write-back, then the mux.
  always_comb begin
    if (gnt_addr == '0) begin
      rd_data = '0;
    end else if (wr_en && (wr_addr == gnt_addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = rf_rdata;
    end
  end

  // Next pointer and lock state; a held lock always returns to ARB afterwards.
  always_comb begin
    ptr_d   = ptr_q;
    state_d = state_q;
    owner_d = owner_q;
    if (lock_hold) begin
      ptr_d   = wrap_inc(owner_q);
      state_d = ST_ARB;
    end else begin
      state_d = ST_ARB;
      if (gnt_vld) begin
        ptr_d = wrap_inc(gnt_idx);
        if (req_lock[gnt_idx]) begin
          state_d = ST_LOCKED;
          owner_d = gnt_idx;
        end
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Response registers; id and data hold their last value when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= gnt_oh;
      if (gnt_vld) begin
        rsp_id_q   <= gnt_idx;
        rsp_data_q <= rd_data;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule
